noc_config_injector: RTL

- Upstream stage of the 4-node mesh.
- Queues 11-bit configuration words per processor from a host write port.
- Drives them onto p0..p3_configure, one word per processor_ready_signals handshake cycle.
- Replaces static per-processor configure registers with a sequenced, back-pressured feed.

---
 rtl/noc_config_injector_if.sv | 17 +
 rtl/noc_config_injector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/noc_config_injector_if.sv
// Host write bus for noc_config_injector.
//   wr_en    : host write strobe
//   wr_proc  : target processor index 0..3
//   wr_data  : configuration word
//   wr_ready : target FIFO not full (driven by the injector)
// Modports: master = host side, slave = injector side.
interface noc_config_injector_if #(
  parameter int unsigned CFG_W = 11
);
  logic             wr_en;
  logic [1:0]       wr_proc;
  logic [CFG_W-1:0] wr_data;
  logic             wr_ready;

  modport master (output wr_en, output wr_proc, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_proc, input wr_data, output wr_ready);
endinterface

// File: rtl/noc_config_injector.sv
// noc_config_injector: upstream stage of the 4-node mesh. Queues host-written
// configuration words in one FIFO per processor and feeds them onto
// p0..p3_configure, one word per processor_ready_signals handshake
// (ready high -> word presented, ready low -> consumed, ready high -> free).
//
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   host (slave modport)    : wr_en / wr_proc / wr_data in, wr_ready out
//   processor_ready_signals : bit i = processor i ready
//   p0..p3_configure        : configuration word per processor
//   busy                    : bit i = FIFO i non-empty or channel i mid-handshake
//   all_done                : no channel busy
//   issued_count            : words acknowledged by the mesh, wraps at 16 bits
//   err_overflow            : sticky, write attempted while target FIFO full
//   err_timeout (optional)  : sticky per channel, mesh never consumed a word
//
// Optional feature macro: NOC_CFG_TIMEOUT_EN enables a per-channel watchdog
// that abandons a word held for TIMEOUT_CYC cycles without ready falling.
module noc_config_injector #(
  parameter int unsigned      DEPTH       = 4,
  parameter int unsigned      CFG_W       = 11,
  parameter logic [CFG_W-1:0] RESET_WORD  = '0,
  parameter int unsigned      TIMEOUT_CYC = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  noc_config_injector_if.slave host,
  input  logic [3:0]           processor_ready_signals,
  output logic [CFG_W-1:0]     p0_configure,
  output logic [CFG_W-1:0]     p1_configure,
  output logic [CFG_W-1:0]     p2_configure,
  output logic [CFG_W-1:0]     p3_configure,
  output logic [3:0]           busy,
  output logic                 all_done,
  output logic [15:0]          issued_count,
  output logic                 err_overflow
`ifdef NOC_CFG_TIMEOUT_EN
  ,
  output logic [3:0]           err_timeout
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACK
  } state_t;

  state_t           r_state [4];
  logic [CFG_W-1:0] r_mem   [4][DEPTH];
  logic [AW-1:0]    r_wptr  [4];
  logic [AW-1:0]    r_rptr  [4];
  logic [AW:0]      r_cnt   [4];
  logic [3:0]       r_full;
  logic [CFG_W-1:0] r_cfg   [4];
  logic [15:0]      r_issued_count;
  logic             r_err_overflow;

  logic [3:0]       w_wr;
  logic [3:0]       w_pop;
  logic [3:0]       w_ack;
  logic [3:0]       w_busy;
  logic [2:0]       w_ack_cnt;
  logic             w_overflow;

`ifdef NOC_CFG_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_to_cnt [4];
  logic [3:0]    r_err_timeout;
  logic [3:0]    w_to;
`endif

  always_comb begin
    w_wr      = '0;
    w_pop     = '0;
    w_ack     = '0;
    w_busy    = '0;
    w_ack_cnt = '0;
`ifdef NOC_CFG_TIMEOUT_EN
    w_to      = '0;
`endif
    for (int unsigned i = 0; i < 4; i++) begin
      // full is the registered flag, so a pop in the same cycle never frees room
      w_wr[i]   = host.wr_en && (host.wr_proc == 2'(i)) && !r_full[i];
      w_pop[i]  = (r_state[i] == ST_IDLE) && (r_cnt[i] != '0) && processor_ready_signals[i];
      w_ack[i]  = (r_state[i] == ST_ISSUE) && !processor_ready_signals[i];
      w_busy[i] = (r_cnt[i] != '0) || (r_state[i] != ST_IDLE);
`ifdef NOC_CFG_TIMEOUT_EN
      w_to[i]   = (r_state[i] == ST_ISSUE) && processor_ready_signals[i] &&
                  (r_to_cnt[i] == TO_LAST);
`endif
      w_ack_cnt = w_ack_cnt + 3'(w_ack[i]);
    end
    w_overflow = host.wr_en && r_full[host.wr_proc];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_state[i] <= ST_IDLE;
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_cnt[i]   <= '0;
        r_cfg[i]   <= RESET_WORD;
`ifdef NOC_CFG_TIMEOUT_EN
        r_to_cnt[i] <= '0;
`endif
      end
      r_full         <= '0;
      r_issued_count <= '0;
      r_err_overflow <= 1'b0;
`ifdef NOC_CFG_TIMEOUT_EN
      r_err_timeout  <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_wr[i]) begin
          r_mem[i][r_wptr[i]] <= host.wr_data;
          r_wptr[i]           <= r_wptr[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_cfg[i]  <= r_mem[i][r_rptr[i]];
          r_rptr[i] <= r_rptr[i] + 1'b1;
        end
        // simultaneous write and pop leave the occupancy unchanged
        if (w_wr[i] && !w_pop[i]) begin
          r_cnt[i]  <= r_cnt[i] + 1'b1;
          r_full[i] <= ((r_cnt[i] + 1'b1) == FULL_CNT);
        end else if (!w_wr[i] && w_pop[i]) begin
          r_cnt[i]  <= r_cnt[i] - 1'b1;
          r_full[i] <= 1'b0;
        end

        unique case (r_state[i])
          ST_IDLE: begin
            if (w_pop[i]) r_state[i] <= ST_ISSUE;
          end
          ST_ISSUE: begin
            if (w_ack[i]) r_state[i] <= ST_ACK;
`ifdef NOC_CFG_TIMEOUT_EN
            else if (w_to[i]) r_state[i] <= ST_IDLE;
`endif
          end
          ST_ACK: begin
            if (processor_ready_signals[i]) r_state[i] <= ST_IDLE;
          end
          default: r_state[i] <= ST_IDLE;
        endcase

`ifdef NOC_CFG_TIMEOUT_EN
        if ((r_state[i] == ST_ISSUE) && !w_ack[i] && !w_to[i]) begin
          r_to_cnt[i] <= r_to_cnt[i] + 1'b1;
        end else begin
          r_to_cnt[i] <= '0;
        end
`endif
      end

      // several channels can acknowledge in the same cycle
      r_issued_count <= r_issued_count + 16'(w_ack_cnt);
      if (w_overflow) r_err_overflow <= 1'b1;
`ifdef NOC_CFG_TIMEOUT_EN
      r_err_timeout <= r_err_timeout | w_to;
`endif
    end
  end

  assign host.wr_ready = !r_full[host.wr_proc];
  assign p0_configure  = r_cfg[0];
  assign p1_configure  = r_cfg[1];
  assign p2_configure  = r_cfg[2];
  assign p3_configure  = r_cfg[3];
  assign busy          = w_busy;
  assign all_done      = ~|w_busy;
  assign issued_count  = r_issued_count;
  assign err_overflow  = r_err_overflow;
`ifdef NOC_CFG_TIMEOUT_EN
  assign err_timeout   = r_err_timeout;
`endif

endmodule
